// File: rtl/htif_pkg.sv
// htif_pkg: shared widths and FSM encodings for the host/target mailbox bridge
package htif_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LINK_WIDTH = 8;
  localparam int BEATS = DEF_DATA_WIDTH / DEF_LINK_WIDTH;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CLEAR} tx_state_e;
  typedef enum logic {RX_COLLECT, RX_PEND} rx_state_e;
endpackage

// File: rtl/htif_word_shifter.sv
// htif_word_shifter: word-wide right shift register with a wrapping beat counter
module htif_word_shifter
  import htif_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINK_WIDTH = DEF_LINK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  shift_i,
  input  logic [LINK_WIDTH-1:0] shift_in_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  last_beat_o
);
  localparam int NBEATS = DATA_WIDTH / LINK_WIDTH;
  localparam int BEAT_W = NBEATS > 1 ? $clog2(NBEATS) : 1;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  assign word_o = word_q;
  assign last_beat_o = beat_q == BEAT_W'(NBEATS - 1);
  // New beats enter at the top so the first beat ends up in the low byte
  always_comb begin
    word_d = load_i ? load_data_i : shift_i ? {shift_in_i, word_q[DATA_WIDTH-1:LINK_WIDTH]} : word_q;
    beat_d = load_i ? '0 : shift_i ? (last_beat_o ? '0 : beat_q + BEAT_W'(1)) : beat_q;
  end
  // Register the word and beat count
  always_ff @(posedge clk) begin
    word_q <= reset ? '0 : word_d;
    beat_q <= reset ? '0 : beat_d;
  end
endmodule

// File: rtl/host_target_bridge.sv
// host_target_bridge: moves tohost words out to the host link and host words into fromhost
module host_target_bridge
  import htif_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINK_WIDTH = DEF_LINK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tohost_value,
  input  logic                  tohost_busy,
  output logic                  tohost_clear,
  input  logic [DATA_WIDTH-1:0] fromhost_value,
  input  logic                  fromhost_busy,
  output logic                  fromhost_we,
  output logic [DATA_WIDTH-1:0] fromhost_wdata,
  output logic                  h_tx_valid,
  input  logic                  h_tx_ready,
  output logic [LINK_WIDTH-1:0] h_tx_data,
  input  logic                  h_rx_valid,
  output logic                  h_rx_ready,
  input  logic [LINK_WIDTH-1:0] h_rx_data,
  output logic                  rx_drop
);
  tx_state_e tx_q, tx_d;
  rx_state_e rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d, tx_shift, rx_word, rx_next;
  logic tx_load, tx_last, rx_last, rx_fire;
  assign tx_load = tx_q == TX_IDLE && tohost_value != '0;
  assign h_tx_data = tx_shift[LINK_WIDTH-1:0];
  assign tx_word_d = tx_load ? tohost_value : tx_word_q;
  assign rx_fire = h_rx_valid && h_rx_ready;
  assign rx_next = {h_rx_data, rx_word[DATA_WIDTH-1:LINK_WIDTH]};
  htif_word_shifter #(.DATA_WIDTH(DATA_WIDTH), .LINK_WIDTH(LINK_WIDTH)) u_tx (
    .clk(clk), .reset(reset), .load_i(tx_load), .load_data_i(tohost_value),
    .shift_i(h_tx_valid && h_tx_ready), .shift_in_i('0), .word_o(tx_shift), .last_beat_o(tx_last)
  );
  htif_word_shifter #(.DATA_WIDTH(DATA_WIDTH), .LINK_WIDTH(LINK_WIDTH)) u_rx (
    .clk(clk), .reset(reset), .load_i(1'b0), .load_data_i('0),
    .shift_i(rx_fire), .shift_in_i(h_rx_data), .word_o(rx_word), .last_beat_o(rx_last)
  );
  // TX: capture a non-zero tohost, send it, then clear only if the target has not replaced it
  always_comb begin
    tx_d = tx_q;
    h_tx_valid = 1'b0;
    tohost_clear = 1'b0;
    case (tx_q)
      TX_IDLE: tx_d = tx_load ? TX_SEND : TX_IDLE;
      TX_SEND: begin
        h_tx_valid = 1'b1;
        tx_d = h_tx_ready && tx_last ? TX_CLEAR : TX_SEND;
      end
      TX_CLEAR: begin
        tohost_clear = !tohost_busy && tohost_value == tx_word_q;
        tx_d = tohost_busy ? TX_CLEAR : TX_IDLE;
      end
      default: tx_d = TX_IDLE;
    endcase
  end
  // RX: assemble host bytes, drop zero words, hand off once fromhost is free
  always_comb begin
    h_rx_ready = rx_q == RX_COLLECT && !reset;
    rx_drop = rx_fire && rx_last && rx_next == '0;
    fromhost_we = rx_q == RX_PEND && fromhost_value == '0 && !fromhost_busy;
    fromhost_wdata = rx_q == RX_PEND ? rx_word : '0;
    rx_d = rx_q == RX_PEND ? (fromhost_we ? RX_COLLECT : RX_PEND)
                           : (rx_fire && rx_last && rx_next != '0 ? RX_PEND : RX_COLLECT);
  end
  // State and captured tohost word
  always_ff @(posedge clk) begin
    tx_q <= reset ? TX_IDLE : tx_d;
    rx_q <= reset ? RX_COLLECT : rx_d;
    tx_word_q <= reset ? '0 : tx_word_d;
  end
endmodule

// File: tb/tb_host_target_bridge.sv
// tb_host_target_bridge: directed tests for the mailbox bridge with a tohost PCR model
module tb_host_target_bridge;
  logic clk = 0, reset = 1;
  logic [31:0] tohost_value, th_q, cpu_wdata = 0, fromhost_value = 0, fromhost_wdata;
  logic cpu_we = 0, tohost_busy, tohost_clear, fromhost_busy = 0, fromhost_we;
  logic h_tx_valid, h_tx_ready = 0, h_rx_valid = 0, h_rx_ready, rx_drop;
  logic [7:0] h_tx_data, h_rx_data = 0;
  int total = 0, bad = 0;
  logic [7:0] got [16];
  int ng, nclr, clr_at, clr_cyc, first_cyc, stall_bad, nwe, ndrop;
  logic [31:0] wd;

  host_target_bridge dut (
    .clk(clk), .reset(reset), .tohost_value(tohost_value), .tohost_busy(tohost_busy),
    .tohost_clear(tohost_clear), .fromhost_value(fromhost_value), .fromhost_busy(fromhost_busy),
    .fromhost_we(fromhost_we), .fromhost_wdata(fromhost_wdata), .h_tx_valid(h_tx_valid),
    .h_tx_ready(h_tx_ready), .h_tx_data(h_tx_data), .h_rx_valid(h_rx_valid),
    .h_rx_ready(h_rx_ready), .h_rx_data(h_rx_data), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // tohost PCR: CPU write wins, otherwise the bridge clear zeroes it
  always @(posedge clk)
    if (reset) th_q <= 0;
    else if (cpu_we) th_q <= cpu_wdata;
    else if (tohost_clear) th_q <= 0;
  assign tohost_value = th_q;
  assign tohost_busy = cpu_we;

  task step;
    @(posedge clk);
    #1;
  endtask

  task th_write(input logic [31:0] v);
    cpu_we = 1;
    cpu_wdata = v;
    step;
    cpu_we = 0;
  endtask

  task run_tx(input int ncyc, input logic [31:0] rdy, input int wr_at, input logic [31:0] wr_val);
    logic prev_stall;
    logic [7:0] prev_data;
    ng = 0; nclr = 0; clr_at = -1; clr_cyc = -1; first_cyc = -1; stall_bad = 0;
    prev_stall = 0; prev_data = 0;
    for (int i = 0; i < ncyc; i++) begin
      h_tx_ready = rdy[i % 32];
      cpu_we = (i == wr_at);
      cpu_wdata = wr_val;
      @(negedge clk);
      if (prev_stall && (!h_tx_valid || h_tx_data !== prev_data)) stall_bad++;
      if (h_tx_valid && h_tx_ready && ng < 16) begin
        if (first_cyc < 0) first_cyc = i;
        got[ng] = h_tx_data;
        ng++;
      end
      if (tohost_clear) begin nclr++; clr_at = ng; clr_cyc = i; end
      prev_stall = h_tx_valid && !h_tx_ready;
      prev_data = h_tx_data;
      step;
    end
    cpu_we = 0;
    h_tx_ready = 0;
  endtask

  task run_rx(input int nbytes, input logic [63:0] bytes, input int ncyc);
    int k;
    k = 0; nwe = 0; ndrop = 0; wd = 0;
    for (int i = 0; i < ncyc; i++) begin
      h_rx_valid = k < nbytes;
      h_rx_data = bytes[8*k +: 8];
      @(negedge clk);
      if (h_rx_valid && h_rx_ready) k++;
      if (fromhost_we) begin nwe++; wd = fromhost_wdata; end
      if (rx_drop) ndrop++;
      step;
    end
    h_rx_valid = 0;
  endtask

  task test_reset;
    reset = 1;
    step;
    @(negedge clk);
    total++;
    if ({tohost_clear, fromhost_we, h_tx_valid, h_rx_ready, rx_drop} !== 5'b0) begin
      $display("FAIL reset_strobes got=%b want=00000", {tohost_clear, fromhost_we, h_tx_valid, h_rx_ready, rx_drop});
      bad++;
    end
    total++;
    if (fromhost_wdata !== 0 || h_tx_data !== 0) begin
      $display("FAIL reset_data got wdata=%h txdata=%h want 0", fromhost_wdata, h_tx_data);
      bad++;
    end
    reset = 0;
    step;
    @(negedge clk);
    total++;
    if (h_rx_ready !== 1) begin $display("FAIL reset_rx_ready got=%b want=1", h_rx_ready); bad++; end
    step;
  endtask

  task test_tx_basic;
    logic [7:0] exp [4];
    exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    th_write(32'hDEADBEEF);
    run_tx(20, 32'hFFFFFFFF, -1, 0);
    total++;
    if (ng !== 4) begin $display("FAIL tx_basic_count got=%0d want=4", ng); bad++; end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got[j] !== exp[j]) begin $display("FAIL tx_basic_byte%0d got=%h want=%h", j, got[j], exp[j]); bad++; end
    end
    total++;
    if (nclr !== 1 || clr_at !== 4) begin $display("FAIL tx_basic_clear got n=%0d at=%0d want n=1 at=4", nclr, clr_at); bad++; end
    total++;
    if (first_cyc !== 1 || clr_cyc !== 5) begin $display("FAIL tx_basic_timing got first=%0d clr=%0d want 1,5", first_cyc, clr_cyc); bad++; end
    total++;
    if (th_q !== 0) begin $display("FAIL tx_basic_tohost got=%h want=0", th_q); bad++; end
  endtask

  task test_tx_stall;
    logic [7:0] exp [4];
    exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    th_write(32'hA1B2C3D4);
    run_tx(20, 32'hFFFFFFF3, -1, 0);
    total++;
    if (ng !== 4) begin $display("FAIL tx_stall_count got=%0d want=4", ng); bad++; end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got[j] !== exp[j]) begin $display("FAIL tx_stall_byte%0d got=%h want=%h", j, got[j], exp[j]); bad++; end
    end
    total++;
    if (stall_bad !== 0) begin $display("FAIL tx_stall_hold got=%0d want=0 violations", stall_bad); bad++; end
    total++;
    if (nclr !== 1 || clr_cyc !== 7) begin $display("FAIL tx_stall_clear got n=%0d cyc=%0d want 1,7", nclr, clr_cyc); bad++; end
  endtask

  task test_tx_overwrite;
    logic [7:0] exp [8];
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    th_write(32'h00000001);
    run_tx(24, 32'hFFFFFFFF, 2, 32'h12345678);
    total++;
    if (ng !== 8) begin $display("FAIL tx_over_count got=%0d want=8", ng); bad++; end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (got[j] !== exp[j]) begin $display("FAIL tx_over_byte%0d got=%h want=%h", j, got[j], exp[j]); bad++; end
    end
    total++;
    if (nclr !== 1 || clr_at !== 8) begin $display("FAIL tx_over_clear got n=%0d at=%0d want n=1 at=8", nclr, clr_at); bad++; end
    total++;
    if (th_q !== 0) begin $display("FAIL tx_over_tohost got=%h want=0", th_q); bad++; end
  endtask

  task test_rx_basic;
    fromhost_value = 0;
    run_rx(4, 64'h80000001, 8);
    total++;
    if (nwe !== 1 || wd !== 32'h80000001) begin $display("FAIL rx_basic_write got n=%0d data=%h want 1,80000001", nwe, wd); bad++; end
    total++;
    if (ndrop !== 0) begin $display("FAIL rx_basic_drop got=%0d want=0", ndrop); bad++; end
    @(negedge clk);
    total++;
    if (h_rx_ready !== 1 || fromhost_wdata !== 0) begin $display("FAIL rx_basic_idle got rdy=%b wdata=%h want 1,0", h_rx_ready, fromhost_wdata); bad++; end
    step;
  endtask

  task test_rx_backpressure;
    int viol;
    fromhost_value = 5;
    run_rx(4, 64'h7, 4);
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (h_rx_ready !== 0 || fromhost_we !== 0 || fromhost_wdata !== 32'h7) viol++;
      step;
    end
    total++;
    if (viol !== 0 || nwe !== 0) begin $display("FAIL rx_pend_hold got viol=%0d writes=%0d want 0,0", viol, nwe); bad++; end
    fromhost_value = 0;
    fromhost_busy = 1;
    @(negedge clk);
    total++;
    if (fromhost_we !== 0) begin $display("FAIL rx_pend_busy got we=%b want=0", fromhost_we); bad++; end
    step;
    fromhost_busy = 0;
    @(negedge clk);
    total++;
    if (fromhost_we !== 1 || fromhost_wdata !== 32'h7) begin $display("FAIL rx_pend_write got we=%b data=%h want 1,00000007", fromhost_we, fromhost_wdata); bad++; end
    step;
    @(negedge clk);
    total++;
    if (fromhost_we !== 0 || h_rx_ready !== 1 || fromhost_wdata !== 0) begin $display("FAIL rx_pend_done got we=%b rdy=%b data=%h want 0,1,0", fromhost_we, h_rx_ready, fromhost_wdata); bad++; end
    step;
  endtask

  task test_rx_drop_reset;
    fromhost_value = 0;
    run_rx(4, 64'h0, 7);
    total++;
    if (ndrop !== 1 || nwe !== 0) begin $display("FAIL rx_drop got drops=%0d writes=%0d want 1,0", ndrop, nwe); bad++; end
    run_rx(2, 64'hBBAA, 2);
    reset = 1;
    @(negedge clk);
    total++;
    if (fromhost_we !== 0 || tohost_clear !== 0 || h_rx_ready !== 0) begin $display("FAIL rx_reset_quiet got we=%b clr=%b rdy=%b want 0,0,0", fromhost_we, tohost_clear, h_rx_ready); bad++; end
    step;
    reset = 0;
    run_rx(4, 64'h44332211, 7);
    total++;
    if (nwe !== 1 || wd !== 32'h44332211) begin $display("FAIL rx_after_reset got n=%0d data=%h want 1,44332211", nwe, wd); bad++; end
  endtask

  initial begin
    test_reset;
    test_tx_basic;
    test_tx_stall;
    test_tx_overwrite;
    test_rx_basic;
    test_rx_backpressure;
    test_rx_drop_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
